crossbar_rr_arbiter: RTL and testbench

// - Round-robin output arbiter for the 3x3 packet switch crossbar.
// - Pops head words from the per-input circular packet RAMs and grants each output port
//   to at most one input per cycle. Drives the crossbar mux selects and output-RAM writes.
// - Sits between the input packet RAMs (write side owned by ingress) and the megamux/output RAMs.
// - Replaces fixed-priority scheduling with per-output fair arbitration plus output backpressure.

---
 rtl/switch_pkg.sv | 52 +++++
 rtl/rr_pick3.sv | 35 +++
 rtl/crossbar_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_crossbar_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and helpers for the 3x3 packet switch crossbar arbiter.
package switch_pkg;

    localparam int NPORTS = 3;

    localparam logic [1:0] DEST_DROP = 2'b00;
    localparam logic [1:0] DEST_OUT0 = 2'b01;
    localparam logic [1:0] DEST_OUT1 = 2'b10;
    localparam logic [1:0] DEST_OUT2 = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        HEAD  = 2'd2
    } in_state_t;

    // Output port index for a destination field; 2'd3 means no port (drop).
    function automatic logic [1:0] dest_to_port(input logic [1:0] dest);
        logic [1:0] port;
        case (dest)
            DEST_OUT0: port = 2'd0;
            DEST_OUT1: port = 2'd1;
            DEST_OUT2: port = 2'd2;
            default:   port = 2'd3;
        endcase
        return port;
    endfunction

    // One-hot grant to mux select encoding: 0 = none, 1..3 = input index + 1.
    function automatic logic [1:0] onehot_to_sel(input logic [2:0] gnt);
        logic [1:0] sel;
        case (gnt)
            3'b001:  sel = 2'd1;
            3'b010:  sel = 2'd2;
            3'b100:  sel = 2'd3;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

    // Round-robin pointer after a win: winner + 1 modulo 3, from the select code.
    function automatic logic [1:0] sel_to_next_ptr(input logic [1:0] sel);
        logic [1:0] ptr;
        case (sel)
            2'd1:    ptr = 2'd1;
            2'd2:    ptr = 2'd2;
            default: ptr = 2'd0;
        endcase
        return ptr;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first request at or after ptr, wrapping 0,1,2.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic       valid
);

    // Priority search starting at ptr; ptr value 3 is treated as 0.
    always_comb begin
        gnt   = 3'b000;
        valid = |req;
        case (ptr)
            2'd1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else             gnt = 3'b000;
            end
            2'd2: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else             gnt = 3'b000;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else             gnt = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/crossbar_rr_arbiter.sv
// Per-output round-robin arbiter for the 3x3 crossbar: pops input RAM heads,
// drops destination-00 words and drives registered mux selects / output writes.
module crossbar_rr_arbiter
    import switch_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data    [NPORTS],
    input  logic [ADDR_W-1:0] in_wr_addr [NPORTS],
    input  logic [NPORTS-1:0] out_ready,
    output logic [ADDR_W-1:0] in_rd_addr [NPORTS],
    output logic [NPORTS-1:0] in_rden,
    output logic [1:0]        mux_sel    [NPORTS],
    output logic [NPORTS-1:0] out_wr,
    output logic [15:0]       drop_cnt
);

    in_state_t         state_r     [NPORTS];
    in_state_t         state_s     [NPORTS];
    logic [ADDR_W-1:0] rd_addr_r   [NPORTS];
    logic [ADDR_W-1:0] next_addr_s [NPORTS];
    logic [DATA_W-1:0] head_r      [NPORTS];
    logic [DATA_W-1:0] head_word_s [NPORTS];
    logic [NPORTS-1:0] fresh_r;
    logic [NPORTS-1:0] drop_s;
    logic [NPORTS-1:0] taken_s;
    logic [NPORTS-1:0] retire_s;
    logic [2:0]        req_s       [NPORTS];
    logic [2:0]        gnt_s       [NPORTS];
    logic [NPORTS-1:0] vld_s;
    logic [NPORTS-1:0] grant_s;
    logic [1:0]        rr_ptr_r    [NPORTS];
    logic [1:0]        mux_sel_r   [NPORTS];
    logic [NPORTS-1:0] out_wr_r;
    logic [15:0]       drop_cnt_r;
    logic [15:0]       drop_next_s;
    logic [1:0]        drop_inc_s;
    logic [16:0]       drop_sum_s;

    // Head word (RAM data on the first HEAD cycle, held copy afterwards) and per-output requests.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            head_word_s[i] = fresh_r[i] ? in_data[i] : head_r[i];
            drop_s[i]      = (state_r[i] == HEAD) && (head_word_s[i][1:0] == DEST_DROP);
        end
        for (int o = 0; o < NPORTS; o++) begin
            req_s[o] = 3'b000;
            for (int i = 0; i < NPORTS; i++) begin
                req_s[o][i] = (state_r[i] == HEAD) &&
                              (dest_to_port(head_word_s[i][1:0]) == 2'(o));
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_pick
        rr_pick3 u_pick (
            .req   (req_s[g]),
            .ptr   (rr_ptr_r[g]),
            .gnt   (gnt_s[g]),
            .valid (vld_s[g])
        );
    end

    // Grant qualification with backpressure, head retirement and input FSM next state.
    always_comb begin
        grant_s = vld_s & out_ready;
        for (int i = 0; i < NPORTS; i++) begin
            taken_s[i] = 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                taken_s[i] = taken_s[i] | (grant_s[o] & gnt_s[o][i]);
            end
            retire_s[i]    = taken_s[i] | drop_s[i];
            next_addr_s[i] = rd_addr_r[i] + ADDR_W'(1);
            state_s[i]     = state_r[i];
            case (state_r[i])
                EMPTY: begin
                    if (rd_addr_r[i] != in_wr_addr[i]) state_s[i] = FETCH;
                    else                               state_s[i] = EMPTY;
                end
                FETCH: state_s[i] = HEAD;
                HEAD: begin
                    if (!retire_s[i])                         state_s[i] = HEAD;
                    else if (next_addr_s[i] != in_wr_addr[i]) state_s[i] = FETCH;
                    else                                      state_s[i] = EMPTY;
                end
                default: state_s[i] = EMPTY;
            endcase
        end
    end

    // Saturating drop counter update; several inputs may drop in the same cycle.
    always_comb begin
        drop_inc_s = {1'b0, drop_s[0]} + {1'b0, drop_s[1]} + {1'b0, drop_s[2]};
        drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
        if (drop_sum_s[16]) drop_next_s = 16'hFFFF;
        else                drop_next_s = drop_sum_s[15:0];
    end

    // Input FSM state, read pointers and head registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fresh_r <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                state_r[i]   <= EMPTY;
                rd_addr_r[i] <= '0;
                head_r[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                state_r[i] <= state_s[i];
                fresh_r[i] <= (state_r[i] == FETCH);
                if (state_r[i] == HEAD) head_r[i] <= head_word_s[i];
                if (retire_s[i]) rd_addr_r[i] <= next_addr_s[i];
            end
        end
    end

    // Round-robin pointers, registered crossbar controls and drop count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_wr_r   <= '0;
            drop_cnt_r <= 16'd0;
            for (int o = 0; o < NPORTS; o++) begin
                rr_ptr_r[o]  <= 2'd0;
                mux_sel_r[o] <= 2'd0;
            end
        end else begin
            drop_cnt_r <= drop_next_s;
            for (int o = 0; o < NPORTS; o++) begin
                if (grant_s[o]) begin
                    rr_ptr_r[o]  <= sel_to_next_ptr(onehot_to_sel(gnt_s[o]));
                    mux_sel_r[o] <= onehot_to_sel(gnt_s[o]);
                    out_wr_r[o]  <= 1'b1;
                end else begin
                    mux_sel_r[o] <= 2'd0;
                    out_wr_r[o]  <= 1'b0;
                end
            end
        end
    end

    // Output port mapping.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            in_rd_addr[i] = rd_addr_r[i];
            in_rden[i]    = (state_r[i] == FETCH);
            mux_sel[i]    = mux_sel_r[i];
        end
        out_wr   = out_wr_r;
        drop_cnt = drop_cnt_r;
    end

endmodule

// File: tb/tb_crossbar_rr_arbiter.sv
// Self-checking bench for crossbar_rr_arbiter: RAM/ingress model, per-input word
// queues as reference, directed scenarios plus a randomized traffic phase.
module tb_crossbar_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rdata   [3];
    logic [11:0] wr      [3];
    logic [2:0]  out_ready;
    logic [11:0] rd_addr [3];
    logic [2:0]  rden;
    logic [1:0]  mux_sel [3];
    logic [2:0]  out_wr;
    logic [15:0] drop_cnt;

    logic [31:0] mem [3][4096];
    logic [31:0] q [3][$];
    int          log_sel [3][$];
    int          exp_drops = 0;
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  prev_ready = 3'b000;

    always #5 clk = ~clk;

    crossbar_rr_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (rdata),
        .in_wr_addr (wr),
        .out_ready  (out_ready),
        .in_rd_addr (rd_addr),
        .in_rden    (rden),
        .mux_sel    (mux_sel),
        .out_wr     (out_wr),
        .drop_cnt   (drop_cnt)
    );

    // Synchronous input RAMs: data valid the cycle after a read enable.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) rdata[i] <= $urandom();
            else if (rden[i]) rdata[i] <= mem[i][rd_addr[i]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [1:0] d);
        logic [31:0] w;
        w = $urandom();
        w[1:0] = d;
        mem[i][wr[i]] = w;
        q[i].push_back(w);
        wr[i] = wr[i] + 12'd1;
        if (d == 2'b00) exp_drops++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            wr[i] = 12'd0;
            q[i].delete();
            log_sel[i].delete();
        end
        exp_drops = 0;
    endtask

    task automatic drain(input string tag);
        bit done;
        logic [31:0] w;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            done = (rd_addr[0] == wr[0]) && (rd_addr[1] == wr[1]) && (rd_addr[2] == wr[2]);
        end
        step(); step(); step();
        check({tag, "_timeout"}, 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) check({tag, "_rd_eq_wr"}, 32'(rd_addr[i]), 32'(wr[i]));
        for (int i = 0; i < 3; i++) begin
            while (q[i].size() > 0) begin
                w = q[i].pop_front();
                check({tag, "_undelivered"}, 32'(w[1:0]), 32'd0);
            end
        end
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops));
        check({tag, "_idle_wr"}, 32'(out_wr), 32'd0);
    endtask

    // Scoreboard: every write must follow a ready cycle and carry the queue head for that output.
    always @(negedge clk) begin
        int idx;
        logic [31:0] w;
        if (reset_n) begin
            for (int o = 0; o < 3; o++) begin
                if (out_wr[o]) begin
                    check("wr_after_ready", 32'(prev_ready[o]), 32'd1);
                    check("sel_nonzero", 32'(mux_sel[o] != 2'd0), 32'd1);
                    if (mux_sel[o] != 2'd0) begin
                        idx = int'(mux_sel[o]) - 1;
                        while (q[idx].size() > 0 && q[idx][0][1:0] == 2'b00) void'(q[idx].pop_front());
                        check("word_pending", 32'(q[idx].size() > 0), 32'd1);
                        if (q[idx].size() > 0) begin
                            w = q[idx].pop_front();
                            check("word_dest", 32'(w[1:0]), 32'(o + 1));
                            log_sel[o].push_back(idx + 1);
                        end
                    end
                end else begin
                    check("sel_idle", 32'(mux_sel[o]), 32'd0);
                end
            end
            for (int a = 0; a < 3; a++)
                for (int b = a + 1; b < 3; b++)
                    if (out_wr[a] && out_wr[b])
                        check("one_output_per_input", 32'(mux_sel[a] != mux_sel[b]), 32'd1);
            prev_ready = out_ready;
        end else begin
            prev_ready = 3'b000;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        // Reset with random inputs
        reset_n = 1'b0;
        clear_model();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 3; i++) wr[i] = 12'($urandom());
            out_ready = 3'($urandom());
            step();
            for (int i = 0; i < 3; i++) check("rst_rd_addr", 32'(rd_addr[i]), 32'd0);
            for (int i = 0; i < 3; i++) check("rst_mux_sel", 32'(mux_sel[i]), 32'd0);
            check("rst_rden", 32'(rden), 32'd0);
            check("rst_out_wr", 32'(out_wr), 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        end
        clear_model();
        out_ready = 3'b111;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle_rden", 32'(rden), 32'd0);
        end

        // Single word to out1
        push(0, 2'b10);
        step();
        check("sw_rden_c1", 32'(rden), 32'b001);
        check("sw_rd_addr_c1", 32'(rd_addr[0]), 32'd0);
        step();
        check("sw_rden_c2", 32'(rden), 32'd0);
        check("sw_out_wr_c2", 32'(out_wr), 32'd0);
        step();
        check("sw_out_wr_c3", 32'(out_wr), 32'b010);
        check("sw_mux_sel_c3", 32'(mux_sel[1]), 32'd1);
        check("sw_rd_addr_c3", 32'(rd_addr[0]), 32'd1);
        step();
        check("sw_out_wr_c4", 32'(out_wr), 32'd0);
        check("sw_mux_sel_c4", 32'(mux_sel[1]), 32'd0);
        check("sw_rden_c4", 32'(rden), 32'd0);
        step();
        check("sw_empty", 32'(rden), 32'd0);
        check("sw_log", 32'(log_sel[1].size()), 32'd1);

        // Contention on out0
        for (int i = 0; i < 3; i++) log_sel[i].delete();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) push(i, 2'b01);
        drain("cont");
        check("cont_grants", 32'(log_sel[0].size()), 32'd12);
        for (int k = 0; k < 12 && k < log_sel[0].size(); k++)
            check("cont_rr_order", 32'(log_sel[0][k]), 32'((k % 3) + 1));
        check("cont_no_out1", 32'(log_sel[1].size()), 32'd0);
        check("cont_no_out2", 32'(log_sel[2].size()), 32'd0);

        // Backpressure on out2
        for (int i = 0; i < 3; i++) log_sel[i].delete();
        out_ready = 3'b011;
        push(1, 2'b11);
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_no_wr2", 32'(out_wr[2]), 32'd0);
            check("bp_rd_frozen", 32'(rd_addr[1]), 32'(12'(wr[1] - 12'd1)));
        end
        out_ready = 3'b111;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_wr[2]) pulses++;
        end
        check("bp_one_grant", 32'(pulses), 32'd1);
        check("bp_rd_moved", 32'(rd_addr[1]), 32'(wr[1]));
        check("bp_src", 32'(log_sel[2].size() == 1 && log_sel[2][0] == 2), 32'd1);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 2000; c++) begin
            step();
            out_ready = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 3) == 0 && 12'(wr[i] - rd_addr[i]) < 12'd6)
                    push(i, 2'($urandom_range(0, 3)));
        end
        out_ready = 3'b111;
        drain("rand");

        // Bring input 2 up to the top of the address space, then drop two words across the wrap
        for (int c = 0; c < 20000 && wr[2] != 12'hFFF; c++) begin
            step();
            if (12'(wr[2] - rd_addr[2]) < 12'd3) push(2, 2'($urandom_range(0, 3)));
        end
        check("fill_reached", 32'(wr[2]), 32'hFFF);
        drain("fill");
        check("wrap_start", 32'(rd_addr[2]), 32'hFFF);
        push(2, 2'b00);
        push(2, 2'b00);
        drain("wrap");
        check("wrap_rd_addr", 32'(rd_addr[2]), 32'd1);
        check("wrap_empty", 32'(rden[2]), 32'd0);

        // Asynchronous reset between a grant and its output cycle
        push(0, 2'b01);
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        check("ar_out_wr", 32'(out_wr), 32'd0);
        for (int i = 0; i < 3; i++) check("ar_mux_sel", 32'(mux_sel[i]), 32'd0);
        for (int i = 0; i < 3; i++) check("ar_rd_addr", 32'(rd_addr[i]), 32'd0);
        check("ar_drop_cnt", 32'(drop_cnt), 32'd0);
        clear_model();
        step();
        check("ar_out_wr_hold", 32'(out_wr), 32'd0);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("ar_idle_rden", 32'(rden), 32'd0);
            check("ar_idle_wr", 32'(out_wr), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
